// File: rtl/ysyx_23060201_mem_arbiter.sv
// ysyx_23060201_mem_arbiter
//
// Shares the single data-memory port between the IFU (read-only fetch) and
// the LSU (load/store). One transaction is in flight at a time. The winner of
// a round-robin arbitration has its request latched, presented to memory
// until accepted, and the response is steered back to that requester as a
// one-cycle pulse. If memory does not answer within TIMEOUT cycles of the
// request being accepted, the owner receives an error pulse instead.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   ifu_req_*             IFU read request (valid/addr) and ready
//   ifu_resp_*            IFU response pulse, read data, timeout error
//   lsu_req_*             LSU request (valid/wen/addr/wdata/wmask) and ready
//   lsu_resp_*            LSU response pulse, read data, timeout error
//   mem_req_*, mem_addr,
//   mem_wen, mem_wdata,
//   mem_wmask             registered request towards the memory access unit
//   mem_resp_*            memory response (valid/rdata)
//
// Parameter
//   TIMEOUT               cycles waited for a response, legal range 1..255

module ysyx_23060201_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_rdata,
  output logic        ifu_resp_err,

  input  logic        lsu_req_valid,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wmask,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_rdata,
  output logic        lsu_resp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  // Requester encoding for owner and last_grant.
  localparam logic Ifu = 1'b0;
  localparam logic Lsu = 1'b1;

  // Last counter value at which a missing response turns into an error.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        ifu_valid_q, ifu_valid_d;
  logic        ifu_err_q, ifu_err_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic        lsu_valid_q, lsu_valid_d;
  logic        lsu_err_q, lsu_err_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;

  logic        grant_ifu, grant_lsu;
  logic        deliver, deliver_err;
  logic [31:0] deliver_data;

  // Round-robin: a lone requester wins; on a tie the one not granted last.
  always_comb begin
    grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_q == Ifu));
    grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_q == Lsu));
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    cnt_d        = cnt_q;
    deliver      = 1'b0;
    deliver_err  = 1'b0;
    deliver_data = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (grant_lsu) begin
          owner_d = Lsu;
          last_d  = Lsu;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          // Reads never carry a byte mask to memory.
          wmask_d = lsu_req_wen ? lsu_req_wmask : 4'h0;
          state_d = StReq;
        end else if (grant_ifu) begin
          owner_d = Ifu;
          last_d  = Ifu;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = 32'h0;
          wmask_d = 4'h0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          cnt_d   = 8'h0;
          state_d = StResp;
        end
      end
      StResp: begin
        cnt_d = cnt_q + 8'h1;
        // A response arriving on the timeout cycle still counts as success.
        if (mem_resp_valid) begin
          deliver      = 1'b1;
          deliver_data = wen_q ? 32'h0 : mem_resp_rdata;
          state_d      = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          deliver     = 1'b1;
          deliver_err = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response registers: valid/err are single-cycle pulses, rdata holds.
  always_comb begin
    ifu_valid_d = 1'b0;
    ifu_err_d   = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_valid_d = 1'b0;
    lsu_err_d   = 1'b0;
    lsu_rdata_d = lsu_rdata_q;
    if (deliver) begin
      if (owner_q == Lsu) begin
        lsu_valid_d = 1'b1;
        lsu_err_d   = deliver_err;
        lsu_rdata_d = deliver_data;
      end else begin
        ifu_valid_d = 1'b1;
        ifu_err_d   = deliver_err;
        ifu_rdata_d = deliver_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= Ifu;
      last_q      <= Ifu;
      addr_q      <= 32'h0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'h0;
      wmask_q     <= 4'h0;
      cnt_q       <= 8'h0;
      ifu_valid_q <= 1'b0;
      ifu_err_q   <= 1'b0;
      ifu_rdata_q <= 32'h0;
      lsu_valid_q <= 1'b0;
      lsu_err_q   <= 1'b0;
      lsu_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      ifu_valid_q <= ifu_valid_d;
      ifu_err_q   <= ifu_err_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_valid_q <= lsu_valid_d;
      lsu_err_q   <= lsu_err_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  // Ready is suppressed during reset so no handshake is seen that the
  // state registers will discard.
  always_comb begin
    ifu_req_ready  = (state_q == StIdle) && !rst && grant_ifu;
    lsu_req_ready  = (state_q == StIdle) && !rst && grant_lsu;
    ifu_resp_valid = ifu_valid_q;
    ifu_resp_err   = ifu_err_q;
    ifu_resp_rdata = ifu_rdata_q;
    lsu_resp_valid = lsu_valid_q;
    lsu_resp_err   = lsu_err_q;
    lsu_resp_rdata = lsu_rdata_q;
    mem_req_valid  = (state_q == StReq);
    mem_addr       = addr_q;
    mem_wen        = wen_q;
    mem_wdata      = wdata_q;
    mem_wmask      = wmask_q;
  end

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Testbench for ysyx_23060201_mem_arbiter (TIMEOUT = 4). The bench plays
// both requesters and the memory, and predicts every output from a
// transaction-level reference: "is a transaction open, has memory taken it,
// how many cycles have we waited, who got the last grant".

module tb_ysyx_23060201_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  ysyx_23060201_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_req_ready (ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_rdata(ifu_resp_rdata),
    .ifu_resp_err  (ifu_resp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wmask (lsu_req_wmask),
    .lsu_req_ready (lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_rdata(lsu_resp_rdata),
    .lsu_resp_err  (lsu_resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  bit          m_open = 0;     // a transaction has been granted
  bit          m_taken = 0;    // memory accepted it
  int          m_waited = 0;   // cycles spent waiting after acceptance
  int          m_last = 0;     // 0 = IFU, 1 = LSU
  int          m_owner = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_wen = 0;
  logic [3:0]  m_wmask = '0;
  bit          m_ifu_pulse = 0, m_lsu_pulse = 0, m_err = 0;
  logic [31:0] m_rdata = '0;
  bit          m_after_rst = 0;
  bit          m_known = 0;
  int          grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit want_lsu();
    return lsu_req_valid && (!ifu_req_valid || m_last == 0);
  endfunction
  function automatic bit want_ifu();
    return ifu_req_valid && (!lsu_req_valid || m_last == 1);
  endfunction

  // One clock: check outputs at negedge, advance reference at posedge.
  task automatic cycle();
    bit free;
    @(negedge clk);
    free = !rst && !m_open;
    if (lsu_req_ready) grants.push_back(1);
    if (ifu_req_ready) grants.push_back(0);
    if (m_known) begin
      chk("ifu_req_ready", 32'(ifu_req_ready), 32'(free && want_ifu()));
      chk("lsu_req_ready", 32'(lsu_req_ready), 32'(free && want_lsu()));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(m_open && !m_taken));
      chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(m_ifu_pulse));
      chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(m_lsu_pulse));
      if (m_ifu_pulse || m_after_rst) begin
        chk("ifu_resp_rdata", ifu_resp_rdata, m_rdata);
        chk("ifu_resp_err", 32'(ifu_resp_err), 32'(m_err));
      end
      if (m_lsu_pulse || m_after_rst) begin
        chk("lsu_resp_rdata", lsu_resp_rdata, m_rdata);
        chk("lsu_resp_err", 32'(lsu_resp_err), 32'(m_err));
      end
      if ((m_open && !m_taken) || m_after_rst) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", 32'(mem_wen), 32'(m_wen));
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
      end
    end
    @(posedge clk);
    m_ifu_pulse = 0;
    m_lsu_pulse = 0;
    m_err = 0;
    m_after_rst = 0;
    if (rst) begin
      m_open = 0; m_taken = 0; m_waited = 0; m_last = 0; m_owner = 0;
      m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0; m_rdata = '0;
      m_after_rst = 1;
      m_known = 1;
    end else if (!m_open) begin
      if (want_lsu()) begin
        m_open = 1; m_owner = 1; m_last = 1;
        m_addr = lsu_req_addr; m_wen = lsu_req_wen; m_wdata = lsu_req_wdata;
        m_wmask = lsu_req_wen ? lsu_req_wmask : 4'h0;
      end else if (want_ifu()) begin
        m_open = 1; m_owner = 0; m_last = 0;
        m_addr = ifu_req_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
      end
    end else if (!m_taken) begin
      if (mem_req_ready) begin
        m_taken = 1;
        m_waited = 0;
      end
    end else if (mem_resp_valid || m_waited == TO - 1) begin
      m_err = !mem_resp_valid;
      m_rdata = (m_err || m_wen) ? 32'h0 : mem_resp_rdata;
      if (m_owner == 1) m_lsu_pulse = 1; else m_ifu_pulse = 1;
      m_open = 0;
      m_taken = 0;
    end else begin
      m_waited++;
    end
    #1;
  endtask

  task automatic drive(input bit iv, input bit lv, input bit lw, input bit mr, input bit mv);
    ifu_req_valid  = iv;
    lsu_req_valid  = lv;
    lsu_req_wen    = lw;
    mem_req_ready  = mr;
    mem_resp_valid = mv;
    mem_resp_rdata = $urandom;
  endtask

  initial begin
    rst = 1;
    ifu_req_addr = 32'h8000_0000;
    lsu_req_addr = 32'h8000_0100;
    lsu_req_wdata = 32'hDEAD_BEEF;
    lsu_req_wmask = 4'h3;
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 0;

    // Single IFU read returning 0x0000_0413 at minimum latency.
    drive(1, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 1); mem_resp_rdata = 32'h0000_0413; cycle();
    drive(0, 0, 0, 0, 0); cycle();
    cycle();

    // LSU write held off by memory for three cycles.
    drive(0, 1, 1, 0, 0); cycle();
    drive(0, 0, 0, 0, 0); cycle(); cycle(); cycle();
    drive(0, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0); cycle();

    // Tie from reset: expected grant order LSU, IFU, LSU, IFU.
    rst = 1; cycle(); rst = 0;
    grants.delete();
    for (int i = 0; i < 14; i++) begin
      drive(1, 1, 0, 1, 1);
      cycle();
    end
    drive(0, 0, 0, 0, 0); cycle(); cycle();
    chk("grant_count", 32'(grants.size() >= 4), 32'h1);
    if (grants.size() >= 4) begin
      chk("grant0", 32'(grants[0]), 32'h1);
      chk("grant1", 32'(grants[1]), 32'h0);
      chk("grant2", 32'(grants[2]), 32'h1);
      chk("grant3", 32'(grants[3]), 32'h0);
    end

    // Memory never answers: error pulse, then a stray response in idle.
    drive(1, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle();
    drive(0, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0); cycle();

    // Response arrives on the last cycle before the timeout fires.
    drive(0, 1, 0, 1, 0); cycle();
    drive(0, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 0); cycle(); cycle(); cycle();
    drive(0, 0, 0, 0, 1); mem_resp_rdata = 32'h1234_5678; cycle();
    drive(0, 0, 0, 0, 0); cycle();

    // Reset while waiting for the response, then a tie.
    drive(1, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 0); cycle();
    rst = 1; drive(0, 0, 0, 0, 1); cycle();
    rst = 0; drive(1, 1, 1, 1, 0); cycle();
    drive(0, 0, 0, 1, 1); cycle();
    drive(0, 0, 0, 0, 0); cycle(); cycle();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      ifu_req_addr  = $urandom;
      lsu_req_addr  = $urandom;
      lsu_req_wdata = $urandom;
      lsu_req_wmask = 4'($urandom);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
      cycle();
    end
    rst = 0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
